// File: rtl/pqvalue_invbfly.sv
// pqvalue_invbfly: pipelined inverse-NTT (Gentleman-Sande) butterfly.
//   a' = (a + b) mod q,  b' = ((a - b) * zeta) mod q
//   q = 8380417 (Dilithium, sel_red = 0) or 3329 (Kyber, sel_red = 1).
// Valid/ready streaming with one global stall signal shared by every stage.
// Optional macro PQVALUE_INVSCALE_EN adds stage S3, which multiplies both outputs
// by n^-1 for beats tagged with scale = 1 (latency 3 instead of 2).
module pqvalue_invbfly (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [22:0] a_i,
    input  logic [22:0] b_i,
    input  logic [22:0] zeta_i,
    input  logic        sel_red_i,
    input  logic        scale_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [22:0] a_o,
    output logic [22:0] b_o
);

    localparam logic [22:0] QDil    = 23'd8380417;
    localparam logic [22:0] QKyb    = 23'd3329;
    localparam logic [22:0] NInvDil = 23'd8347681;  // 256^-1 mod 8380417
    localparam logic [22:0] NInvKyb = 23'd3303;     // 128^-1 mod 3329

    function automatic logic [22:0] q_of(input logic sel);
        return sel ? QKyb : QDil;
    endfunction

    function automatic logic [22:0] mod_add(input logic [22:0] x, input logic [22:0] y,
                                            input logic sel);
        logic [23:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, q_of(sel)}) s = s - {1'b0, q_of(sel)};
        return 23'(s);
    endfunction

    function automatic logic [22:0] mod_sub(input logic [22:0] x, input logic [22:0] y,
                                            input logic sel);
        logic [23:0] d;
        if (x >= y) d = {1'b0, x} - {1'b0, y};
        else        d = {1'b0, x} + {1'b0, q_of(sel)} - {1'b0, y};
        return 23'(d);
    endfunction

    // Separate constant-divisor reductions, selected afterwards.
    function automatic logic [22:0] mod_mul(input logic [22:0] x, input logic [22:0] y,
                                            input logic sel);
        logic [45:0] p;
        p = 46'(x) * 46'(y);
        if (sel) return 23'(p % 46'(QKyb));
        else     return 23'(p % 46'(QDil));
    endfunction

    logic advance;

    // S1 state
    logic        s1_v_q,    s1_v_d;
    logic [22:0] s1_sum_q,  s1_sum_d;
    logic [22:0] s1_diff_q, s1_diff_d;
    logic [22:0] s1_zeta_q, s1_zeta_d;
    logic        s1_sel_q,  s1_sel_d;
    // S2 state
    logic        s2_v_q,    s2_v_d;
    logic [22:0] s2_a_q,    s2_a_d;
    logic [22:0] s2_b_q,    s2_b_d;
`ifdef PQVALUE_INVSCALE_EN
    logic        s1_scl_q,  s1_scl_d;
    logic        s2_sel_q,  s2_sel_d;
    logic        s2_scl_q,  s2_scl_d;
    // S3 state
    logic        s3_v_q,    s3_v_d;
    logic [22:0] s3_a_q,    s3_a_d;
    logic [22:0] s3_b_q,    s3_b_d;
`else
    logic        unused_scale;
    assign unused_scale = scale_i;
`endif

    // Handshake: whole pipeline moves unless the output beat is blocked.
    always_comb begin
        advance = ~valid_o | ready_i;
        ready_o = advance;
    end

    // Next-state for every stage; data only loads alongside a valid beat.
    always_comb begin
        s1_v_d    = s1_v_q;
        s1_sum_d  = s1_sum_q;
        s1_diff_d = s1_diff_q;
        s1_zeta_d = s1_zeta_q;
        s1_sel_d  = s1_sel_q;
        s2_v_d    = s2_v_q;
        s2_a_d    = s2_a_q;
        s2_b_d    = s2_b_q;
`ifdef PQVALUE_INVSCALE_EN
        s1_scl_d  = s1_scl_q;
        s2_sel_d  = s2_sel_q;
        s2_scl_d  = s2_scl_q;
        s3_v_d    = s3_v_q;
        s3_a_d    = s3_a_q;
        s3_b_d    = s3_b_q;
`endif
        if (advance) begin
            s1_v_d = valid_i;
            if (valid_i) begin
                s1_sum_d  = mod_add(a_i, b_i, sel_red_i);
                s1_diff_d = mod_sub(a_i, b_i, sel_red_i);
                s1_zeta_d = zeta_i;
                s1_sel_d  = sel_red_i;
`ifdef PQVALUE_INVSCALE_EN
                s1_scl_d  = scale_i;
`endif
            end
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_a_d = s1_sum_q;
                s2_b_d = mod_mul(s1_diff_q, s1_zeta_q, s1_sel_q);
`ifdef PQVALUE_INVSCALE_EN
                s2_sel_d = s1_sel_q;
                s2_scl_d = s1_scl_q;
`endif
            end
`ifdef PQVALUE_INVSCALE_EN
            s3_v_d = s2_v_q;
            if (s2_v_q) begin
                if (s2_scl_q) begin
                    s3_a_d = mod_mul(s2_a_q, s2_sel_q ? NInvKyb : NInvDil, s2_sel_q);
                    s3_b_d = mod_mul(s2_b_q, s2_sel_q ? NInvKyb : NInvDil, s2_sel_q);
                end else begin
                    s3_a_d = s2_a_q;
                    s3_b_d = s2_b_q;
                end
            end
`endif
        end
    end

    // Pipeline registers; reset flushes beats and clears data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_v_q    <= 1'b0;
            s1_sum_q  <= '0;
            s1_diff_q <= '0;
            s1_zeta_q <= '0;
            s1_sel_q  <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_a_q    <= '0;
            s2_b_q    <= '0;
`ifdef PQVALUE_INVSCALE_EN
            s1_scl_q  <= 1'b0;
            s2_sel_q  <= 1'b0;
            s2_scl_q  <= 1'b0;
            s3_v_q    <= 1'b0;
            s3_a_q    <= '0;
            s3_b_q    <= '0;
`endif
        end else begin
            s1_v_q    <= s1_v_d;
            s1_sum_q  <= s1_sum_d;
            s1_diff_q <= s1_diff_d;
            s1_zeta_q <= s1_zeta_d;
            s1_sel_q  <= s1_sel_d;
            s2_v_q    <= s2_v_d;
            s2_a_q    <= s2_a_d;
            s2_b_q    <= s2_b_d;
`ifdef PQVALUE_INVSCALE_EN
            s1_scl_q  <= s1_scl_d;
            s2_sel_q  <= s2_sel_d;
            s2_scl_q  <= s2_scl_d;
            s3_v_q    <= s3_v_d;
            s3_a_q    <= s3_a_d;
            s3_b_q    <= s3_b_d;
`endif
        end
    end

    // Output stage is the last stage present in this build.
    always_comb begin
`ifdef PQVALUE_INVSCALE_EN
        valid_o = s3_v_q;
        a_o     = s3_a_q;
        b_o     = s3_b_q;
`else
        valid_o = s2_v_q;
        a_o     = s2_a_q;
        b_o     = s2_b_q;
`endif
    end

endmodule
